// File: rtl/ej32_core.sv
// ej32_core: byte-addressed 32-bit stack processor. Each instruction is a sequence of phases,
// with one access to the 8-bit memory port per cycle.
module ej32_core #(
  parameter int unsigned TIB      = 'h1000,
  parameter int unsigned OBUF     = 'h1400,
  parameter int unsigned DSZ      = 32,
  parameter int unsigned ASZ      = 17,
  parameter int unsigned SS_DEPTH = 32,
  parameter int unsigned RS_DEPTH = 32,
  localparam int unsigned SSW     = $clog2(SS_DEPTH),
  localparam int unsigned RSW     = $clog2(RS_DEPTH)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [7:0]     data_o_i,
  output logic [7:0]     data_o_o,
  output logic [ASZ-1:0] addr_o_o,
  output logic           write_o,
  output logic [7:0]     code_o,
  output logic [2:0]     phase_o,
  output logic [ASZ-1:0] p_o,
  output logic [ASZ-1:0] a_o,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] s_o,
  output logic [SSW-1:0] sp_o,
  output logic [RSW-1:0] rp_o
);

  localparam logic [7:0] OpDup     = 8'h59;
  localparam logic [7:0] OpPop     = 8'h57;
  localparam logic [7:0] OpSwap    = 8'h5f;
  localparam logic [7:0] OpIadd    = 8'h60;
  localparam logic [7:0] OpIsub    = 8'h64;
  localparam logic [7:0] OpIand    = 8'h7e;
  localparam logic [7:0] OpIor     = 8'h80;
  localparam logic [7:0] OpIxor    = 8'h82;
  localparam logic [7:0] OpReturn  = 8'hb1;
  localparam logic [7:0] OpBipush  = 8'h10;
  localparam logic [7:0] OpSipush  = 8'h11;
  localparam logic [7:0] OpGoto    = 8'ha7;
  localparam logic [7:0] OpIfeq    = 8'h99;
  localparam logic [7:0] OpInvoke  = 8'hb6;
  localparam logic [7:0] OpIaload  = 8'h2e;
  localparam logic [7:0] OpBaload  = 8'h33;
  localparam logic [7:0] OpIastore = 8'h4f;
  localparam logic [7:0] OpBastore = 8'h54;

  logic [ASZ-1:0] p_q, p_d, a_q, a_d;
  logic [DSZ-1:0] t_q, t_d;
  logic [SSW-1:0] sp_q, sp_d, ss_wa;
  logic [RSW-1:0] rp_q, rp_d, rs_wa;
  logic [2:0]     phase_q, phase_d;
  logic [7:0]     code_q, code_d;
  logic           ss_we, rs_we;

  logic [DSZ-1:0] ss_q [SS_DEPTH];
  logic [ASZ-1:0] rs_q [RS_DEPTH];

  logic [DSZ-1:0] s_val;
  logic [15:0]    off16;
  logic [ASZ-1:0] br_tgt;
  logic [1:0]     sel;
  logic           unused_cfg;

  assign unused_cfg = ^{TIB, OBUF};
  assign s_val      = ss_q[sp_q];
  // High operand byte is parked in A[15:8] during phase 1 of two-byte-operand opcodes.
  assign off16      = {a_q[15:8], data_o_i};
  assign br_tgt     = p_q - ASZ'(2) + {{(ASZ-16){off16[15]}}, off16};
  assign sel        = 2'(3'd5 - phase_q);
  assign rs_wa      = rp_q + RSW'(1);

  always_comb begin
    p_d      = p_q;
    a_d      = a_q;
    t_d      = t_q;
    sp_d     = sp_q;
    rp_d     = rp_q;
    code_d   = code_q;
    phase_d  = 3'd0;
    addr_o_o = a_q;
    write_o  = 1'b0;
    data_o_o = 8'h00;
    ss_we    = 1'b0;
    ss_wa    = sp_q + SSW'(1);
    rs_we    = 1'b0;
    if (phase_q == 3'd0) begin
      addr_o_o = p_q;
      code_d   = data_o_i;
      p_d      = p_q + ASZ'(1);
      phase_d  = 3'd1;
    end else begin
      case (code_q)
        8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
          ss_we = 1'b1;
          sp_d  = sp_q + SSW'(1);
          t_d   = {{(DSZ-8){1'b0}}, code_q} - DSZ'(3);
        end
        OpDup: begin
          ss_we = 1'b1;
          sp_d  = sp_q + SSW'(1);
        end
        OpPop: begin
          t_d  = s_val;
          sp_d = sp_q - SSW'(1);
        end
        OpSwap: begin
          ss_we = 1'b1;
          ss_wa = sp_q;
          t_d   = s_val;
        end
        OpIadd, OpIsub, OpIand, OpIor, OpIxor: begin
          sp_d = sp_q - SSW'(1);
          case (code_q)
            OpIadd:  t_d = s_val + t_q;
            OpIsub:  t_d = s_val - t_q;
            OpIand:  t_d = s_val & t_q;
            OpIor:   t_d = s_val | t_q;
            default: t_d = s_val ^ t_q;
          endcase
        end
        OpReturn: begin
          p_d  = rs_q[rp_q];
          rp_d = rp_q - RSW'(1);
        end
        OpBipush: begin
          addr_o_o = p_q;
          p_d      = p_q + ASZ'(1);
          ss_we    = 1'b1;
          sp_d     = sp_q + SSW'(1);
          t_d      = {{(DSZ-8){data_o_i[7]}}, data_o_i};
        end
        OpSipush, OpGoto, OpIfeq, OpInvoke: begin
          addr_o_o = p_q;
          p_d      = p_q + ASZ'(1);
          if (phase_q == 3'd1) begin
            a_d[15:8] = data_o_i;
            phase_d   = 3'd2;
          end else begin
            case (code_q)
              OpSipush: begin
                ss_we = 1'b1;
                sp_d  = sp_q + SSW'(1);
                t_d   = {{(DSZ-16){off16[15]}}, off16};
              end
              OpGoto: p_d = br_tgt;
              OpIfeq: begin
                t_d  = s_val;
                sp_d = sp_q - SSW'(1);
                if (t_q == '0) p_d = br_tgt;
              end
              default: begin
                rs_we = 1'b1;
                rp_d  = rs_wa;
                p_d   = {{(ASZ-16){1'b0}}, off16};
              end
            endcase
          end
        end
        OpIaload, OpBaload: begin
          if (phase_q == 3'd1) begin
            a_d     = t_q[ASZ-1:0];
            phase_d = 3'd2;
          end else if (code_q == OpBaload) begin
            t_d = {{(DSZ-8){1'b0}}, data_o_i};
          end else begin
            t_d     = {t_q[DSZ-9:0], data_o_i};
            a_d     = a_q + ASZ'(1);
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
          end
        end
        OpIastore, OpBastore: begin
          if (phase_q == 3'd1) begin
            a_d     = t_q[ASZ-1:0];
            t_d     = s_val;
            sp_d    = sp_q - SSW'(1);
            phase_d = 3'd2;
          end else begin
            write_o  = 1'b1;
            data_o_o = (code_q == OpBastore) ? t_q[7:0] : t_q[{sel, 3'b000} +: 8];
            a_d      = a_q + ASZ'(1);
            if (code_q == OpBastore || phase_q == 3'd5) begin
              t_d  = s_val;
              sp_d = sp_q - SSW'(1);
            end else begin
              phase_d = phase_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      p_q     <= '0;
      a_q     <= '0;
      t_q     <= '0;
      sp_q    <= '0;
      rp_q    <= '0;
      phase_q <= 3'd0;
      code_q  <= 8'h00;
    end else begin
      p_q     <= p_d;
      a_q     <= a_d;
      t_q     <= t_d;
      sp_q    <= sp_d;
      rp_q    <= rp_d;
      phase_q <= phase_d;
      code_q  <= code_d;
    end
  end

  // Stack storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (ss_we) ss_q[ss_wa] <= t_q;
    if (rs_we) rs_q[rs_wa] <= p_q + ASZ'(1);
  end

  assign code_o  = code_q;
  assign phase_o = phase_q;
  assign p_o     = p_q;
  assign a_o     = a_q;
  assign t_o     = t_q;
  assign s_o     = s_val;
  assign sp_o    = sp_q;
  assign rp_o    = rp_q;

endmodule

// File: tb/tb_ej32_core.sv
// Directed bench for ej32_core: byte memory model, register checks and a write scoreboard.
module tb_ej32_core;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  data_o_i, data_o_o, code_o;
  logic [16:0] addr_o_o, p_o, a_o;
  logic        write_o;
  logic [2:0]  phase_o;
  logic [31:0] t_o, s_o;
  logic [4:0]  sp_o, rp_o;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] mem [0:(1<<17)-1];
  wr_t        exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  ej32_core dut (
    .clk      (clk),
    .clr      (clr),
    .data_o_i (data_o_i),
    .data_o_o (data_o_o),
    .addr_o_o (addr_o_o),
    .write_o  (write_o),
    .code_o   (code_o),
    .phase_o  (phase_o),
    .p_o      (p_o),
    .a_o      (a_o),
    .t_o      (t_o),
    .s_o      (s_o),
    .sp_o     (sp_o),
    .rp_o     (rp_o)
  );

  always #5 clk = ~clk;
  assign data_o_i = mem[addr_o_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Commit any write in the current cycle to the memory model, then advance one clock.
  task automatic tick();
    if (write_o === 1'b1) begin
      wr_t e;
      e = '1;
      mem[addr_o_o] = data_o_o;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("wr_addr", {15'd0, addr_o_o}, {15'd0, e.addr});
      chk("wr_data", {24'd0, data_o_o}, {24'd0, e.data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold reset, load a program at address 0 (first byte in the top of v), release.
  task automatic start(input logic [127:0] v, input int n);
    clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int i = 0; i < n; i++) mem[i] = v[8*(n-1-i) +: 8];
    clr = 1'b1;
    #1;
  endtask

  initial begin
    clr = 1'b0;
    #12;

    // Reset and first instruction
    start(128'h05, 1);
    chk("rst_addr", {15'd0, addr_o_o}, 32'd0);
    chk("rst_phase", {29'd0, phase_o}, 32'd0);
    chk("rst_t", t_o, 32'd0);
    chk("rst_sp", {27'd0, sp_o}, 32'd0);
    ticks(2);
    chk("ic2_t", t_o, 32'd2);
    chk("ic2_sp", {27'd0, sp_o}, 32'd1);
    chk("ic2_p", {15'd0, p_o}, 32'd1);

    // ALU and byte sign extension
    start(128'h10_7f_10_03_64_10_ff, 7);
    ticks(6);
    chk("isub_t", t_o, 32'h7c);
    chk("isub_sp", {27'd0, sp_o}, 32'd1);
    ticks(2);
    chk("bipush_ff_t", t_o, 32'hffff_ffff);
    chk("bipush_ff_sp", {27'd0, sp_o}, 32'd2);

    // Conditional branch, taken and untaken
    start(128'h03_99_00_05, 4);
    ticks(5);
    chk("ifeq_tk_p", {15'd0, p_o}, 32'd6);
    chk("ifeq_tk_sp", {27'd0, sp_o}, 32'd0);
    start(128'h04_99_00_05, 4);
    ticks(5);
    chk("ifeq_nt_p", {15'd0, p_o}, 32'd4);
    chk("ifeq_nt_sp", {27'd0, sp_o}, 32'd0);

    // Call and return
    start(128'hb6_01_00, 3);
    mem[17'h100] = 8'hb1;
    ticks(3);
    chk("call_p", {15'd0, p_o}, 32'h100);
    chk("call_rp", {27'd0, rp_o}, 32'd1);
    ticks(2);
    chk("ret_p", {15'd0, p_o}, 32'd3);
    chk("ret_rp", {27'd0, rp_o}, 32'd0);

    // Word store then load back
    start(128'h11_12_34_11_14_00_4f_11_14_00_2e, 11);
    ticks(6);
    chk("sipush_t", t_o, 32'h1400);
    chk("sipush_sp", {27'd0, sp_o}, 32'd2);
    exp_q.push_back('{addr: 17'h1400, data: 8'h00});
    exp_q.push_back('{addr: 17'h1401, data: 8'h00});
    exp_q.push_back('{addr: 17'h1402, data: 8'h12});
    exp_q.push_back('{addr: 17'h1403, data: 8'h34});
    ticks(6);
    chk("iastore_left", exp_q.size(), 32'd0);
    chk("iastore_sp", {27'd0, sp_o}, 32'd0);
    ticks(9);
    chk("iaload_t", t_o, 32'h1234);
    chk("iaload_sp", {27'd0, sp_o}, 32'd1);

    // Asynchronous reset in the middle of iaload
    start(128'h11_14_00_2e, 4);
    ticks(6);
    chk("mid_phase", {29'd0, phase_o}, 32'd3);
    clr = 1'b0;
    #1;
    chk("ar_p", {15'd0, p_o}, 32'd0);
    chk("ar_a", {15'd0, a_o}, 32'd0);
    chk("ar_t", t_o, 32'd0);
    chk("ar_sp", {27'd0, sp_o}, 32'd0);
    chk("ar_rp", {27'd0, rp_o}, 32'd0);
    chk("ar_phase", {29'd0, phase_o}, 32'd0);
    chk("ar_code", {24'd0, code_o}, 32'd0);
    chk("ar_write", {31'd0, write_o}, 32'd0);
    chk("ar_dout", {24'd0, data_o_o}, 32'd0);
    start(128'h11_14_00_2e, 4);
    tick();
    chk("restart_code", {24'd0, code_o}, 32'h11);
    chk("restart_p", {15'd0, p_o}, 32'd1);
    chk("restart_phase", {29'd0, phase_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ej32_core.md
Name: ej32_core

Overview:
- Byte-addressed, JVM-flavoured 32-bit stack processor core.
- Fetches and executes one opcode stream from a single 8-bit-wide memory port.
- Sits between the system byte-memory interface and its surroundings, and exports architectural state for trace.
- Each instruction is a multi-cycle sequence: one memory access per cycle, tracked by a phase counter.

Parameters:
- TIB, 'h1000, input-buffer base address; system address-map constant, not used by core logic.
- OBUF, 'h1400, output-buffer base address; system address-map constant, not used by core logic.
- DSZ, 32, data/stack word width.
- ASZ, 17, byte address width.
- SS_DEPTH, 32, data stack depth (power of two).
- RS_DEPTH, 32, return stack depth (power of two).

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous active-low clear.
- data_o_i  input  8  read byte from memory at addr_o_o, valid in the same cycle.
- data_o_o  output  8  write byte.
- addr_o_o  output  ASZ  memory byte address.
- write_o  output  1  1 = write data_o_o at addr_o_o this cycle.
- code_o  output  8  current opcode register.
- phase_o  output  3  current phase.
- p_o  output  ASZ  program counter P.
- a_o  output  ASZ  address register A.
- t_o  output  DSZ  top of stack T.
- s_o  output  DSZ  second of stack, ss[sp].
- sp_o  output  $clog2(SS_DEPTH)  data stack pointer.
- rp_o  output  $clog2(RS_DEPTH)  return stack pointer.

Behaviour:
- Reset (clr low, async): P=0, A=0, T=0, sp=0, rp=0, phase=0, code=0, write_o=0, data_o_o=0. Stack arrays are not cleared.
- Memory address is P when the opcode is fetched or an instruction operand is read; otherwise it is A. write_o is asserted only in store phases.
- Phase 0 (fetch): code<=data_o_i, P<=P+1, phase<=1. Each instruction's last phase returns phase to 0.
- Push: sp<=sp+1, ss[sp+1]<=T, T<=new value.
- Pop: T<=ss[sp], sp<=sp-1.
- Stack pointers wrap modulo depth; overflow and underflow are not flagged.
- Phase-1-only instructions (2 cycles total):
  - nop 00.
  - iconst_m1..iconst_5 02..08: push -1..5.
  - dup 59.
  - pop 57.
  - swap 5f: T<->ss[sp].
  - iadd 60, isub 64 (S-T), iand 7e, ior 80, ixor 82: T<=S op T, sp-1. Arithmetic is modulo 2^DSZ.
  - return b1: P<=rs[rp], rp-1.
  - Any undefined opcode behaves as nop.
- bipush 10: phase1 push sext(data_o_i), P+1.
- sipush 11: phase1 A[15:8]<=byte, P+1; phase2 push sext16, P+1.
- goto a7 / ifeq 99:
  - 16-bit signed offset read in phases 1–2; target = opcode address + offset.
  - ifeq pops T and branches only if T==0. Untaken: P = opcode address + 3.
- invokevirtual b6:
  - Phases 1–2 read a 16-bit big-endian absolute target.
  - Phase 2: rp+1, rs[rp+1]<=P+1 (address after operands), P<=target.
- iaload 2e:
  - Phase1 A<=T.
  - Phases 2–5 read bytes A..A+3 big-endian, shifting into T (T<={T[23:0],byte}).
- baload 33: phase1 A<=T; phase2 T<=zero-extended byte.
- iastore 4f ( val addr -- ):
  - Phase1 A<=T, pop.
  - Phases 2–5 write T[31:24]..T[7:0] to A..A+3.
  - Final phase pops.
- bastore 54: same as iastore but writes only T[7:0] in a single write phase.
- Reset asserted mid-instruction aborts the instruction; after release, execution restarts at P=0, phase 0.

Test Plan:
- Reset: memory holds 05 (iconst_2) at address 0. Release clr -> addr_o_o=0, phase 0. After 2 cycles: T=2, sp=1, P=1.
- ALU: bipush 7f, bipush 03, isub -> T=0x7c, sp=1. bipush ff -> T=0xffffffff.
- Branch: iconst_0, ifeq +5 at address 1 -> P=6, sp=0. Repeat with iconst_1 -> P=4.
- Call/return: invokevirtual 0x0100 at address 0 -> rp=1, rs[1]=3, P=0x100. A return at 0x100 -> P=3, rp=0.
- Store/load: sipush 0x1234, sipush 0x1400, iastore -> writes 00,00,12,34 at 0x1400..0x1403. sipush 0x1400, iaload -> T=0x1234.
- Async reset mid-iaload (phase 3) -> all outputs return to their reset values immediately, without waiting for a clock edge.
